// File: rtl/ifetch_seq.sv
// ---------------------------------------------------------------------------------------------
// ifetch_seq -- instruction-fetch sequencer
//
// Owns the program counter and fetches WORDS consecutive memory words per instruction into a
// wide instruction register, using a simple request / memory-function-complete handshake.
// The assembled instruction is offered to decode with a valid/ready handshake. If memory does
// not answer within TIMEOUT request cycles the fetch is abandoned and a sticky fault is raised.
//
// Parameters
//   ADDR_W    width of pc, pc_target and mem_addr
//   DATA_W    memory word width
//   WORDS     memory words per instruction (>= 1)
//   TIMEOUT   max request cycles waiting for MFC; 0 waits forever
//   RESET_PC  pc value after reset
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   fetch instruction at pc (sampled in IDLE)
//   pc_load    in   load pc_target into pc (sampled in IDLE only, beats start)
//   pc_target  in   branch/jump target
//   mem_addr   out  registered memory address
//   mem_EN     out  memory enable (high only while requesting)
//   mem_RW     out  1 = read (high only while requesting)
//   mem_rdata  in   memory read data, valid with MFC
//   MFC        in   memory function complete
//   ir_word    out  instruction; word k at [k*DATA_W +: DATA_W]
//   ir_valid   out  ir_word valid
//   ir_ready   in   decode accepts ir_word
//   pc         out  current program counter
//   busy       out  sequencer not idle
//   fault      out  last fetch timed out (sticky until next accepted start)
// ---------------------------------------------------------------------------------------------

module ifetch_seq #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WORDS    = 2,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pc_load,
    input  logic [ADDR_W-1:0]         pc_target,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_EN,
    output logic                      mem_RW,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      MFC,
    output logic [DATA_W*WORDS-1:0]   ir_word,
    output logic                      ir_valid,
    input  logic                      ir_ready,
    output logic [ADDR_W-1:0]         pc,
    output logic                      busy,
    output logic                      fault
);

    localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WORDS - 1);
    // Value of tcnt on the last permitted request cycle.
    localparam logic [TCNT_W-1:0] TLAST    = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(WORDS);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StReq,
        StNext,
        StValid,
        StFault
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic                      mem_en_q, mem_en_d;
    logic                      mem_rw_q, mem_rw_d;
    logic [DATA_W*WORDS-1:0]   ir_word_q, ir_word_d;
    logic                      ir_valid_q, ir_valid_d;
    logic                      fault_q, fault_d;

    // Next-state logic. mem_EN/mem_RW and ir_valid are registered, so they are set on the
    // transition into the state they belong to and cleared on the transition out of it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        mem_addr_d = mem_addr_q;
        mem_en_d   = mem_en_q;
        mem_rw_d   = mem_rw_q;
        ir_word_d  = ir_word_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;

        unique case (state_q)
            StIdle: begin
                if (pc_load) begin
                    pc_d = pc_target;
                end else if (start) begin
                    wcnt_d    = '0;
                    fault_d   = 1'b0;
                    ir_word_d = '0;
                    state_d   = StAddr;
                end
            end

            StAddr: begin
                mem_addr_d = pc_q + ADDR_W'(wcnt_q);
                tcnt_d     = '0;
                mem_en_d   = 1'b1;
                mem_rw_d   = 1'b1;
                state_d    = StReq;
            end

            StReq: begin
                if (MFC) begin
                    // Completion on the last permitted cycle is taken, not the timeout.
                    for (int k = 0; k < int'(WORDS); k++) begin
                        if (wcnt_q == WCNT_W'(k)) begin
                            ir_word_d[k*DATA_W +: DATA_W] = mem_rdata;
                        end
                    end
                    mem_en_d = 1'b0;
                    mem_rw_d = 1'b0;
                    state_d  = StNext;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (tcnt_q == TLAST)) begin
                        mem_en_d = 1'b0;
                        mem_rw_d = 1'b0;
                        state_d  = StFault;
                    end
                end
            end

            StNext: begin
                if (wcnt_q == WLAST) begin
                    pc_d       = pc_q + PC_STEP;
                    ir_valid_d = 1'b1;
                    state_d    = StValid;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = StAddr;
                end
            end

            StValid: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end

            StFault: begin
                // pc is left pointing at the instruction that failed so it can be retried.
                fault_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= PC_RESET;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            mem_addr_q <= '0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            ir_word_q  <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            mem_addr_q <= mem_addr_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            ir_word_q  <= ir_word_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_EN   = mem_en_q;
    assign mem_RW   = mem_rw_q;
    assign ir_word  = ir_word_q;
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;
    assign fault    = fault_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ifetch_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_ifetch_seq -- self-checking bench for ifetch_seq (default parameters: 8-bit address and
// data, 2 words per instruction, TIMEOUT 16, RESET_PC 0).
//
// A small memory responder answers each request after mfc_delay wait cycles and logs the
// address of every request. Fetch vectors come from a table; reset, timeout and pc_load
// corner cases are hand-written sequences. Inputs change and outputs are read 1 time unit
// after the rising edge, or at the falling edge.
// ---------------------------------------------------------------------------------------------

module tb_ifetch_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic [7:0]  mem_addr;
    logic        mem_EN;
    logic        mem_RW;
    logic [7:0]  mem_rdata;
    logic        MFC;
    logic [15:0] ir_word;
    logic        ir_valid;
    logic        ir_ready;
    logic [7:0]  pc;
    logic        busy;
    logic        fault;

    ifetch_seq #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .WORDS    (2),
        .TIMEOUT  (16),
        .RESET_PC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .mem_addr  (mem_addr),
        .mem_EN    (mem_EN),
        .mem_RW    (mem_RW),
        .mem_rdata (mem_rdata),
        .MFC       (MFC),
        .ir_word   (ir_word),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc        (pc),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem [256];
    logic [7:0] addr_q [$];
    int         mfc_delay = 0;
    int         en_count  = 0;
    int         wait_cnt  = 0;

    initial begin
        MFC       = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_EN === 1'b1) begin
                if (wait_cnt == 0) addr_q.push_back(mem_addr);
                en_count++;
                if (wait_cnt >= mfc_delay) begin
                    MFC       = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    MFC = 1'b0;
                end
                wait_cnt++;
            end else begin
                MFC      = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  pc0;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          delay;
        logic [15:0] ir;
        logic [7:0]  npc;
        int          lat;
    } vec_t;

    vec_t vecs [4];

    // Cycles counted from the edge that launches start: 3*WORDS+1 plus one per wait cycle.
    task automatic wait_valid(output int cyc);
        tick();
        start = 1'b0;
        cyc   = 1;
        while (ir_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic load_pc(input logic [7:0] t);
        pc_load   = 1'b1;
        pc_target = t;
        tick();
        pc_load   = 1'b0;
    endtask

    task automatic accept();
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [7:0] a1;
        int         cyc;
        string      tag;
        tag = $sformatf("vec%0d", i);
        a1  = v.pc0 + 8'd1;
        load_pc(v.pc0);
        mem[v.pc0] = v.w0;
        mem[a1]    = v.w1;
        addr_q.delete();
        mfc_delay  = v.delay;
        start      = 1'b1;
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, v.lat);
        check({tag, "_ir_word"}, {16'h0, ir_word}, {16'h0, v.ir});
        check({tag, "_pc"}, {24'h0, pc}, {24'h0, v.npc});
        check({tag, "_nreq"}, addr_q.size(), 2);
        if (addr_q.size() >= 2) begin
            check({tag, "_addr0"}, {24'h0, addr_q[0]}, {24'h0, v.pc0});
            check({tag, "_addr1"}, {24'h0, addr_q[1]}, {24'h0, a1});
        end
        ir_ready = 1'b0;
        repeat (5) tick();
        check({tag, "_hold_valid"}, {31'h0, ir_valid}, 32'h1);
        check({tag, "_hold_word"}, {16'h0, ir_word}, {16'h0, v.ir});
        accept();
        check({tag, "_released"}, {30'h0, ir_valid, busy}, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        rst       = 1'b0;
        start     = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;
        ir_ready  = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        vecs[0] = '{pc0: 8'h10, w0: 8'hA5, w1: 8'h3C, delay: 0, ir: 16'h3CA5, npc: 8'h12, lat: 7};
        vecs[1] = '{pc0: 8'h40, w0: 8'h11, w1: 8'h22, delay: 3, ir: 16'h2211, npc: 8'h42, lat: 13};
        vecs[2] = '{pc0: 8'hFF, w0: 8'h5A, w1: 8'hC3, delay: 0, ir: 16'hC35A, npc: 8'h01, lat: 7};
        vecs[3] = '{pc0: 8'h7E, w0: 8'h00, w1: 8'hFF, delay: 1, ir: 16'hFF00, npc: 8'h80, lat: 9};

        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset_pc", {24'h0, pc}, 32'h0);
        check("reset_ctrl", {27'h0, mem_EN, mem_RW, ir_valid, busy, fault}, 32'h0);
        check("reset_addr_word", {8'h0, mem_addr, ir_word}, 32'h0);

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Reset while the second word is being requested: first word already captured.
        load_pc(8'h33);
        mem[8'h33] = 8'hEE;
        mem[8'h34] = 8'h77;
        mfc_delay  = 0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midreq_en", {30'h0, mem_EN, busy}, 32'h3);
        check("midreq_partial", {16'h0, ir_word}, 32'h00EE);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_ctrl", {27'h0, mem_EN, mem_RW, ir_valid, busy, fault}, 32'h0);
        check("rst_addr_word", {8'h0, mem_addr, ir_word}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("rst_release_idle", {31'h0, busy}, 32'h0);

        // Timeout: MFC never arrives.
        load_pc(8'h20);
        mem[8'h20] = 8'h12;
        mem[8'h21] = 8'h34;
        mfc_delay  = 1000;
        en_count   = 0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("to_idle", {31'h0, busy}, 32'h0);
        check("to_req_cycles", en_count, 16);
        check("to_fault", {31'h0, fault}, 32'h1);
        check("to_pc_kept", {24'h0, pc}, 32'h20);
        repeat (2) tick();
        check("to_fault_sticky", {29'h0, fault, mem_EN, ir_valid}, 32'h4);

        // Retry: MFC on the 16th request cycle of each word is accepted.
        mfc_delay = 15;
        en_count  = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("retry_fault_cleared", {31'h0, fault}, 32'h0);
        cyc = 1;
        while (ir_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("retry_latency", cyc, 7 + 2 * 15);
        check("retry_no_fault", {31'h0, fault}, 32'h0);
        check("retry_req_cycles", en_count, 32);
        check("retry_ir_word", {16'h0, ir_word}, 32'h3412);
        check("retry_pc", {24'h0, pc}, 32'h22);
        accept();

        // pc_load and start together: load wins, no fetch.
        pc_load   = 1'b1;
        start     = 1'b1;
        pc_target = 8'h80;
        tick();
        pc_load = 1'b0;
        start   = 1'b0;
        check("load_beats_start_pc", {24'h0, pc}, 32'h80);
        check("load_beats_start_idle", {31'h0, busy}, 32'h0);
        tick();
        check("load_beats_start_noreq", {30'h0, busy, mem_EN}, 32'h0);

        // Fetch from the loaded target; pc_load held during the fetch is ignored.
        mem[8'h80] = 8'hBE;
        mem[8'h81] = 8'hEF;
        addr_q.delete();
        mfc_delay = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        pc_load   = 1'b1;
        pc_target = 8'h99;
        cyc       = 1;
        while (ir_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        pc_load = 1'b0;
        check("target_latency", cyc, 7);
        check("target_first_addr", (addr_q.size() > 0) ? {24'h0, addr_q[0]} : 32'hFFFF, 32'h80);
        check("target_ir_word", {16'h0, ir_word}, 32'hEFBE);
        check("target_pc_ignores_load", {24'h0, pc}, 32'h82);
        accept();
        check("target_done", {30'h0, busy, ir_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
                 n_err, n_checks);
        $fatal(1);
    end

endmodule
